// File: rtl/imul_req_arbiter.sv
// Shares one integer multiplier among NREQ requesters: round-robin request
// arbitration, with responses routed back in issue order through a tag FIFO.
module imul_req_arbiter #(
    parameter int NREQ         = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_val,
    output logic [NREQ-1:0]     req_rdy,
    input  logic [64*NREQ-1:0]  req_msg,
    output logic [NREQ-1:0]     resp_val,
    input  logic [NREQ-1:0]     resp_rdy,
    output logic [31:0]         resp_msg,
    output logic                mul_req_val,
    input  logic                mul_req_rdy,
    output logic [63:0]         mul_req_msg,
    input  logic                mul_resp_val,
    output logic                mul_resp_rdy,
    input  logic [31:0]         mul_resp_msg
);

    localparam int PW = $clog2(NREQ);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);

    logic [PW-1:0] prio_q,  prio_d;
    logic [AW-1:0] head_q,  head_d;
    logic [AW-1:0] tail_q,  tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] tag_mem [MAX_INFLIGHT];

    logic          any_val;
    logic [PW-1:0] grant;
    logic [PW-1:0] scan_idx;
    logic          fifo_empty;
    logic          can_issue;
    logic          issue_fire;
    logic          ret_fire;
    logic [PW-1:0] owner;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------

    // Rotating scan: the first valid requester at or after prio wins.
    always_comb begin
        // NOTE: every combinational output gets a default up front, so no
        // path through the loop can leave it unassigned and infer a latch.
        any_val  = 1'b0;
        grant    = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(prio_q) + k) % NREQ);
            if (!any_val && req_val[scan_idx]) begin
                any_val = 1'b1;
                grant   = scan_idx;
            end
        end
    end

    assign fifo_empty  = (count_q == '0);
    assign can_issue   = (count_q != FULL_CNT) && reset;
    assign mul_req_val = can_issue && any_val;
    assign mul_req_msg = req_msg[int'(grant)*64 +: 64];
    assign issue_fire  = mul_req_val && mul_req_rdy;

    always_comb begin
        req_rdy = '0;
        if (can_issue && any_val && mul_req_rdy) begin
            req_rdy[grant] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Return side
    // ------------------------------------------------------------------

    // The head tag names the owner of the oldest outstanding request.
    assign owner        = tag_mem[head_q];
    assign resp_msg     = mul_resp_msg;
    assign mul_resp_rdy = !fifo_empty && resp_rdy[owner];
    assign ret_fire     = mul_resp_val && mul_resp_rdy;

    always_comb begin
        resp_val = '0;
        for (int i = 0; i < NREQ; i++) begin
            resp_val[i] = mul_resp_val && !fifo_empty && (owner == PW'(i));
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------

    always_comb begin
        prio_d  = prio_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Priority only rotates on an actual issue, never on idle or stall.
        if (issue_fire) begin
            prio_d = (grant == LAST_REQ) ? '0 : grant + 1'b1;
            tail_d = tail_q + 1'b1;
        end
        if (ret_fire) begin
            head_d = head_q + 1'b1;
        end

        case ({issue_fire, ret_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop
            // samples the pre-edge value regardless of statement order.
            prio_q  <= prio_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the tag storage is deliberately not reset; an entry is only read
    // while count says it holds a tag written by an earlier push.
    always_ff @(posedge clk) begin
        if (issue_fire) begin
            tag_mem[tail_q] <= grant;
        end
    end

`ifndef SYNTHESIS
    a_no_orphan_resp : assert property (
        @(posedge clk) disable iff (!reset) !(mul_resp_val && fifo_empty)
    ) else $error("imul_req_arbiter: multiplier response with nothing in flight");

    function automatic string line_trace();
        string s;
        s = "";
        for (int i = 0; i < NREQ; i++) begin
            s = {s, $sformatf("%b%b:%h ", req_val[i], req_rdy[i], req_msg[64*i +: 64])};
        end
        s = {s, $sformatf("(%0d %0d)", prio_q, count_q)};
        for (int i = 0; i < NREQ; i++) begin
            s = {s, $sformatf(" %b%b:%h", resp_val[i], resp_rdy[i], resp_msg)};
        end
        return s;
    endfunction
`endif

endmodule

// File: tb/tb_imul_req_arbiter.sv
// Directed and random bench for imul_req_arbiter: a 2-requester instance for
// the directed scenarios and a 3-requester, 2-deep instance for random traffic.
module tb_imul_req_arbiter;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: NREQ=2, MAX_INFLIGHT=4
    logic [1:0]   a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
    logic [127:0] a_req_msg;
    logic [31:0]  a_resp_msg;
    logic         a_mreq_val, a_mreq_rdy, a_mresp_val, a_mresp_rdy;
    logic [63:0]  a_mreq_msg;
    logic [31:0]  a_mresp_msg;

    imul_req_arbiter #(.NREQ(2), .MAX_INFLIGHT(4)) dut_a (
        .clk(clk), .reset(reset),
        .req_val(a_req_val), .req_rdy(a_req_rdy), .req_msg(a_req_msg),
        .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_msg(a_resp_msg),
        .mul_req_val(a_mreq_val), .mul_req_rdy(a_mreq_rdy), .mul_req_msg(a_mreq_msg),
        .mul_resp_val(a_mresp_val), .mul_resp_rdy(a_mresp_rdy), .mul_resp_msg(a_mresp_msg)
    );

    // Instance B: NREQ=3, MAX_INFLIGHT=2
    logic [2:0]   b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
    logic [191:0] b_req_msg;
    logic [31:0]  b_resp_msg;
    logic         b_mreq_val, b_mreq_rdy, b_mresp_val, b_mresp_rdy;
    logic [63:0]  b_mreq_msg;
    logic [31:0]  b_mresp_msg;

    imul_req_arbiter #(.NREQ(3), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .reset(reset),
        .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
        .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg),
        .mul_req_val(b_mreq_val), .mul_req_rdy(b_mreq_rdy), .mul_req_msg(b_mreq_msg),
        .mul_resp_val(b_mresp_val), .mul_resp_rdy(b_mresp_rdy), .mul_resp_msg(b_mresp_msg)
    );

    // Shared harness state: request sources, delivered responses, multiplier queue
    logic [63:0] src_mem [3][512];
    int          src_n   [3];
    int          src_rd  [3];
    logic [31:0] got     [3][512];
    int          got_n   [3];
    logic [31:0] mq      [16];
    int          mq_rd, mq_wr, mq_cnt;
    int          grant_log [64];
    int          gl_n;
    int          dlv_log [64];
    int          dl_n;
    bit          seen_rv [3];
    bit          rrdy_en [3];
    bit          mreq_rdy_en, mresp_en;
    int          n_issue;
    bit          s_issue, s_ret;
    logic [1:0]  s_req_rdy;

    task automatic clear_harness();
        for (int i = 0; i < 3; i++) begin
            src_n[i] = 0; src_rd[i] = 0; got_n[i] = 0;
            seen_rv[i] = 1'b0; rrdy_en[i] = 1'b0;
        end
        mq_rd = 0; mq_wr = 0; mq_cnt = 0;
        gl_n = 0; dl_n = 0; n_issue = 0;
        mreq_rdy_en = 1'b0; mresp_en = 1'b0;
        s_issue = 1'b0; s_ret = 1'b0; s_req_rdy = 2'b00;
    endtask

    task automatic push_src(input int i, input logic [31:0] a, input logic [31:0] b);
        src_mem[i][src_n[i]] = {a, b};
        src_n[i]++;
    endtask

    task automatic drive_a();
        for (int i = 0; i < 2; i++) begin
            a_req_val[i]          = (src_rd[i] < src_n[i]);
            a_req_msg[64*i +: 64] = src_mem[i][src_rd[i]];
            a_resp_rdy[i]         = rrdy_en[i];
        end
        a_mreq_rdy  = mreq_rdy_en;
        a_mresp_val = mresp_en && (mq_cnt != 0);
        a_mresp_msg = mq[mq_rd];
    endtask

    task automatic idle_b();
        b_req_val = '0; b_req_msg = '0; b_resp_rdy = '0;
        b_mreq_rdy = 1'b0; b_mresp_val = 1'b0; b_mresp_msg = '0;
    endtask

    task automatic mq_update(input bit ret, input bit iss, input logic [31:0] prod);
        if (!reset) begin
            mq_rd = 0; mq_wr = 0; mq_cnt = 0;
        end else begin
            if (ret) begin mq_rd = (mq_rd + 1) % 16; mq_cnt--; end
            if (iss) begin mq[mq_wr] = prod; mq_wr = (mq_wr + 1) % 16; mq_cnt++; end
        end
    endtask

    // One clock of instance A: sample at negedge, update models, drive after posedge
    task automatic step_a();
        logic [1:0]  rq_fire;
        logic [31:0] prod;
        @(negedge clk);
        rq_fire   = a_req_val & a_req_rdy;
        s_req_rdy = a_req_rdy;
        s_issue   = a_mreq_val && a_mreq_rdy;
        s_ret     = a_mresp_val && a_mresp_rdy;
        prod      = a_mreq_msg[63:32] * a_mreq_msg[31:0];
        for (int i = 0; i < 2; i++) begin
            if (rq_fire[i] && gl_n < 64) begin grant_log[gl_n] = i; gl_n++; end
            if (a_resp_val[i]) seen_rv[i] = 1'b1;
            if (a_resp_val[i] && a_resp_rdy[i] && got_n[i] < 512) begin
                got[i][got_n[i]] = a_resp_msg;
                got_n[i]++;
                if (dl_n < 64) begin dlv_log[dl_n] = i; dl_n++; end
            end
        end
        if (s_issue) n_issue++;
        @(posedge clk);
        #1;
        mq_update(s_ret, s_issue, prod);
        for (int i = 0; i < 2; i++) if (rq_fire[i]) src_rd[i]++;
        drive_a();
    endtask

    task automatic run_a(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step_a();
            done = (got_n[0] == src_n[0]) && (got_n[1] == src_n[1]) && (mq_cnt == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d responses, expected %0d/%0d",
                     name, got_n[0], got_n[1], src_n[0], src_n[1]);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_harness();
        drive_a();
        idle_b();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        clear_harness();
        push_src(0, 32'd1, 32'd1);
        push_src(1, 32'd1, 32'd1);
        mreq_rdy_en = 1'b1;
        rrdy_en     = '{1'b1, 1'b1, 1'b1};
        drive_a();
        idle_b();
        a_mresp_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_req_rdy !== 2'b00) begin errors++; $display("FAIL reset_req_rdy: got %b expected 00", a_req_rdy); end
        checks++; if (a_mreq_val !== 1'b0) begin errors++; $display("FAIL reset_mul_req_val: got %b expected 0", a_mreq_val); end
        checks++; if (a_resp_val !== 2'b00) begin errors++; $display("FAIL reset_resp_val: got %b expected 00", a_resp_val); end
        checks++; if (a_mresp_rdy !== 1'b0) begin errors++; $display("FAIL reset_mul_resp_rdy: got %b expected 0", a_mresp_rdy); end
        checks++; if (b_req_rdy !== 3'b000) begin errors++; $display("FAIL reset_b_req_rdy: got %b expected 000", b_req_rdy); end
        clear_harness();
        drive_a();
    endtask

    task automatic test_single();
        apply_reset();
        mreq_rdy_en = 1'b1; mresp_en = 1'b1;
        rrdy_en     = '{1'b1, 1'b1, 1'b1};
        push_src(0, 32'd3, 32'd5);
        push_src(0, 32'hFFFF_FFFF, 32'd2);
        drive_a();
        run_a(50, "single");
        checks++; if (got_n[0] !== 2) begin errors++; $display("FAIL single_count: got %0d expected 2", got_n[0]); end
        checks++; if (got[0][0] !== 32'h0000_000F) begin errors++; $display("FAIL single_p0: got %h expected 0000000f", got[0][0]); end
        checks++; if (got[0][1] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL single_p1: got %h expected fffffffe", got[0][1]); end
        checks++; if (seen_rv[1] !== 1'b0) begin errors++; $display("FAIL single_rv1: got %b expected 0", seen_rv[1]); end
    endtask

    task automatic test_fairness();
        logic [31:0] exp0, exp1;
        apply_reset();
        mreq_rdy_en = 1'b1; mresp_en = 1'b1;
        rrdy_en     = '{1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            push_src(0, 32'(k), 32'd2);
            push_src(1, 32'(k), 32'd3);
        end
        drive_a();
        run_a(100, "fair");
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (grant_log[k] !== k % 2) begin
                errors++; $display("FAIL fair_grant%0d: got %0d expected %0d", k, grant_log[k], k % 2);
            end
        end
        for (int k = 0; k < 4; k++) begin
            exp0 = 32'(k * 2);
            exp1 = 32'(k * 3);
            checks++; if (got[0][k] !== exp0) begin errors++; $display("FAIL fair_r0_%0d: got %0d expected %0d", k, got[0][k], exp0); end
            checks++; if (got[1][k] !== exp1) begin errors++; $display("FAIL fair_r1_%0d: got %0d expected %0d", k, got[1][k], exp1); end
        end
    endtask

    task automatic test_inflight_limit();
        logic [31:0] exp;
        apply_reset();
        mreq_rdy_en = 1'b1; mresp_en = 1'b0;
        rrdy_en     = '{1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            push_src(0, 32'(k + 1), 32'(k + 1));
            push_src(1, 32'(k + 2), 32'd1);
        end
        drive_a();
        repeat (10) step_a();
        checks++; if (n_issue !== 4) begin errors++; $display("FAIL limit_issues: got %0d expected 4", n_issue); end
        checks++; if (s_req_rdy !== 2'b00) begin errors++; $display("FAIL limit_req_rdy: got %b expected 00", s_req_rdy); end
        mresp_en = 1'b1;
        drive_a();
        step_a();
        checks++; if (s_ret !== 1'b1) begin errors++; $display("FAIL limit_first_ret: got %b expected 1", s_ret); end
        checks++; if (s_issue !== 1'b0) begin errors++; $display("FAIL limit_no_issue_on_pop: got %b expected 0", s_issue); end
        step_a();
        checks++; if (s_issue !== 1'b1) begin errors++; $display("FAIL limit_issue_resumes: got %b expected 1", s_issue); end
        run_a(200, "limit");
        for (int k = 0; k < 6; k++) begin
            exp = 32'((k + 1) * (k + 1));
            checks++; if (got[0][k] !== exp) begin errors++; $display("FAIL limit_r0_%0d: got %0d expected %0d", k, got[0][k], exp); end
            exp = 32'(k + 2);
            checks++; if (got[1][k] !== exp) begin errors++; $display("FAIL limit_r1_%0d: got %0d expected %0d", k, got[1][k], exp); end
        end
    endtask

    task automatic test_hol_blocking();
        logic [31:0] exp1 [5];
        exp1 = '{32'd20, 32'd42, 32'd72, 32'd1, 32'd4};
        apply_reset();
        mreq_rdy_en = 1'b1; mresp_en = 1'b1;
        rrdy_en     = '{1'b0, 1'b1, 1'b1};
        push_src(0, 32'd2, 32'd3);
        push_src(1, 32'd4, 32'd5);
        push_src(1, 32'd6, 32'd7);
        push_src(1, 32'd8, 32'd9);
        push_src(1, 32'd1, 32'd1);
        push_src(1, 32'd2, 32'd2);
        drive_a();
        repeat (5) step_a();
        checks++; if (got_n[0] !== 0) begin errors++; $display("FAIL hol_r0_held: got %0d expected 0", got_n[0]); end
        checks++; if (got_n[1] !== 0) begin errors++; $display("FAIL hol_r1_blocked: got %0d expected 0", got_n[1]); end
        checks++; if (seen_rv[1] !== 1'b0) begin errors++; $display("FAIL hol_rv1_blocked: got %b expected 0", seen_rv[1]); end
        checks++; if (n_issue !== 4) begin errors++; $display("FAIL hol_issues: got %0d expected 4", n_issue); end
        rrdy_en[0] = 1'b1;
        drive_a();
        run_a(100, "hol");
        checks++; if (got[0][0] !== 32'd6) begin errors++; $display("FAIL hol_r0: got %0d expected 6", got[0][0]); end
        checks++; if (dlv_log[0] !== 0) begin errors++; $display("FAIL hol_first_owner: got %0d expected 0", dlv_log[0]); end
        checks++; if (dlv_log[1] !== 1) begin errors++; $display("FAIL hol_second_owner: got %0d expected 1", dlv_log[1]); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (got[1][k] !== exp1[k]) begin errors++; $display("FAIL hol_r1_%0d: got %0d expected %0d", k, got[1][k], exp1[k]); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        mreq_rdy_en = 1'b1; mresp_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_src(0, 32'd1, 32'd1);
            push_src(1, 32'd1, 32'd1);
        end
        drive_a();
        repeat (3) step_a();
        checks++; if (n_issue !== 3) begin errors++; $display("FAIL areset_inflight: got %0d expected 3", n_issue); end
        mresp_en = 1'b1;
        drive_a();
        #1;
        checks++; if (a_resp_val !== 2'b01) begin errors++; $display("FAIL areset_pre_resp_val: got %b expected 01", a_resp_val); end
        checks++; if (a_req_rdy !== 2'b10) begin errors++; $display("FAIL areset_pre_req_rdy: got %b expected 10", a_req_rdy); end
        reset = 1'b0;
        #1;
        checks++; if (a_resp_val !== 2'b00) begin errors++; $display("FAIL areset_resp_val: got %b expected 00", a_resp_val); end
        checks++; if (a_req_rdy !== 2'b00) begin errors++; $display("FAIL areset_req_rdy: got %b expected 00", a_req_rdy); end
        checks++; if (a_mreq_val !== 1'b0) begin errors++; $display("FAIL areset_mul_req_val: got %b expected 0", a_mreq_val); end
        checks++; if (a_mresp_rdy !== 1'b0) begin errors++; $display("FAIL areset_mul_resp_rdy: got %b expected 0", a_mresp_rdy); end
        clear_harness();
        drive_a();
        repeat (2) step_a();
        mreq_rdy_en = 1'b1; mresp_en = 1'b1;
        rrdy_en     = '{1'b1, 1'b1, 1'b1};
        push_src(0, 32'd7, 32'd7);
        push_src(1, 32'd5, 32'd5);
        drive_a();
        reset = 1'b1;
        step_a();
        checks++; if (s_req_rdy !== 2'b01) begin errors++; $display("FAIL areset_first_grant_rdy: got %b expected 01", s_req_rdy); end
        checks++; if (grant_log[0] !== 0) begin errors++; $display("FAIL areset_first_grant: got %0d expected 0", grant_log[0]); end
        run_a(50, "areset");
        checks++; if (got[0][0] !== 32'd49) begin errors++; $display("FAIL areset_r0: got %0d expected 49", got[0][0]); end
        checks++; if (got[1][0] !== 32'd25) begin errors++; $display("FAIL areset_r1: got %0d expected 25", got[1][0]); end
    endtask

    // One clock of instance B with random handshakes; requests hold until they fire
    task automatic step_b();
        logic [2:0]  rq_fire;
        logic [31:0] prod;
        bit          iss, ret;
        @(negedge clk);
        rq_fire = b_req_val & b_req_rdy;
        iss     = b_mreq_val && b_mreq_rdy;
        ret     = b_mresp_val && b_mresp_rdy;
        prod    = b_mreq_msg[63:32] * b_mreq_msg[31:0];
        for (int i = 0; i < 3; i++) begin
            if (b_resp_val[i] && b_resp_rdy[i] && got_n[i] < 512) begin
                got[i][got_n[i]] = b_resp_msg;
                got_n[i]++;
            end
        end
        @(posedge clk);
        #1;
        mq_update(ret, iss, prod);
        for (int i = 0; i < 3; i++) begin
            if (rq_fire[i]) src_rd[i]++;
            if (!(b_req_val[i] && !rq_fire[i])) begin
                b_req_val[i]          = (src_rd[i] < src_n[i]) && ($urandom_range(0, 3) != 0);
                b_req_msg[64*i +: 64] = src_mem[i][src_rd[i]];
            end
            b_resp_rdy[i] = ($urandom_range(0, 2) != 0);
        end
        b_mreq_rdy  = ($urandom_range(0, 2) != 0);
        b_mresp_val = (mq_cnt != 0) && ($urandom_range(0, 2) != 0);
        b_mresp_msg = mq[mq_rd];
    endtask

    task automatic test_random_stress();
        bit          done;
        int          bad;
        logic [31:0] exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 500; k++) push_src(i, $urandom, $urandom);
        end
        done = 1'b0;
        for (int c = 0; c < 40000 && !done; c++) begin
            step_b();
            done = (got_n[0] == 500) && (got_n[1] == 500) && (got_n[2] == 500);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_n[i] !== 500) begin errors++; $display("FAIL stress_count_r%0d: got %0d expected 500", i, got_n[i]); end
            bad = -1;
            for (int k = 0; k < got_n[i] && k < 500; k++) begin
                exp = src_mem[i][k][63:32] * src_mem[i][k][31:0];
                if (bad < 0 && got[i][k] !== exp) bad = k;
            end
            checks++;
            if (bad >= 0) begin
                exp = src_mem[i][bad][63:32] * src_mem[i][bad][31:0];
                errors++;
                $display("FAIL stress_stream_r%0d[%0d]: got %h expected %h", i, bad, got[i][bad], exp);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_harness();
        drive_a();
        idle_b();
        test_reset();
        test_single();
        test_fairness();
        test_inflight_limit();
        test_hol_blocking();
        test_async_reset();
        test_random_stress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
